// File: rtl/redundant_resolver_seq.sv
// Resolves a redundant (sum, carry, carry) triple into binary, SEG_LEN bits per cycle, LSB first.
// Define RESOLVER_EARLY_ACCEPT_EN to accept the next triple in the same cycle a result is taken.
module redundant_resolver_seq #(
  parameter int BIT_LEN = 1024,
  parameter int SEG_LEN = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] in_s,
  input  logic [BIT_LEN-1:0] in_c2,
  input  logic [BIT_LEN-1:0] in_c4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] out_sum,
  output logic [1:0]         out_carry
);
  localparam int NUM_SEG = BIT_LEN / SEG_LEN;
  localparam int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  generate
    if (SEG_LEN < 1 || BIT_LEN % SEG_LEN != 0) begin : g_bad_cfg
      $error("redundant_resolver_seq: BIT_LEN must be a multiple of SEG_LEN");
    end
  endgenerate

`ifdef RESOLVER_EARLY_ACCEPT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef logic [NUM_SEG-1:0][SEG_LEN-1:0] seg_vec_t;

  typedef struct packed {
    seg_vec_t s;
    seg_vec_t c2;
    seg_vec_t c4;
  } triple_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  triple_t            op_q;
  seg_vec_t           sum_q;
  logic [IDX_W-1:0]   seg_idx;
  logic [1:0]         run_carry;
  logic [SEG_LEN+1:0] seg_sum;
  logic               accept;
  logic               last_seg;

  assign in_ready = (state == IDLE) || (EARLY && state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_sum  = sum_q;
  assign last_seg = (seg_idx == IDX_W'(NUM_SEG - 1));

  // Three SEG_LEN-bit terms plus a carry of at most 2 never exceed SEG_LEN+2 bits.
  assign seg_sum = {2'b00, op_q.s[seg_idx]} + {2'b00, op_q.c2[seg_idx]}
                 + {2'b00, op_q.c4[seg_idx]} + {{SEG_LEN{1'b0}}, run_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      sum_q     <= '0;
      seg_idx   <= '0;
      run_carry <= '0;
      out_carry <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          sum_q[seg_idx] <= seg_sum[SEG_LEN-1:0];
          run_carry      <= seg_sum[SEG_LEN+1:SEG_LEN];
          seg_idx        <= seg_idx + IDX_W'(1);
          if (last_seg) begin
            out_carry <= seg_sum[SEG_LEN+1:SEG_LEN];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A new triple overrides the DONE->IDLE step when both handshakes coincide.
      if (accept) begin
        op_q      <= {in_s, in_c2, in_c4};
        seg_idx   <= '0;
        run_carry <= '0;
        state     <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_redundant_resolver_seq.sv
// Directed + randomized bench for redundant_resolver_seq at BIT_LEN=16, SEG_LEN=4.
module tb_redundant_resolver_seq;
  localparam int BL = 16;
  localparam int SL = 4;
  localparam int NS = BL / SL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BL-1:0] in_s, in_c2, in_c4;
  logic          out_valid;
  logic          out_ready;
  logic [BL-1:0] out_sum;
  logic [1:0]    out_carry;

  int checks = 0;
  int errors = 0;

  redundant_resolver_seq #(.BIT_LEN(BL), .SEG_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_c2(in_c2), .in_c4(in_c4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  // Reference: full-width arithmetic sum, result bits and the two bits above.
  function automatic logic [BL+1:0] ref_sum(input logic [BL-1:0] a, b, c);
    return {2'b00, a} + {2'b00, b} + {2'b00, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    in_s  = 16'($urandom);
    in_c2 = 16'($urandom);
    in_c4 = 16'($urandom);
  endtask

  task automatic run_op(input logic [BL-1:0] a, b, c, input int stall, input string tag);
    logic [BL+1:0] exp;
    int lat;
    exp = ref_sum(a, b, c);
    @(negedge clk);
    in_s = a; in_c2 = b; in_c4 = c; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 2) chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    end while (!out_valid && lat < 50);
    chk({tag, "_latency"}, 32'(lat), 32'(NS + 1));
    chk({tag, "_sum"}, 32'(out_sum), 32'(exp[BL-1:0]));
    chk({tag, "_carry"}, 32'(out_carry), 32'(exp[BL+1:BL]));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      scramble();
      chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_sum"}, 32'(out_sum), 32'(exp[BL-1:0]));
      chk({tag, "_stall_carry"}, 32'(out_carry), 32'(exp[BL+1:BL]));
      chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [BL-1:0] ta [3];
    logic [BL-1:0] tb [3];
    logic [BL-1:0] tc [3];
    logic [BL+1:0] e;
    int lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_s = '0; in_c2 = '0; in_c4 = '0;
    #12;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(out_sum), 32'd0);
    chk("reset_carry", 32'(out_carry), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h0101, 16'h0010, 0, "basic");
    run_op(16'hFFFF, 16'h0001, 16'h0000, 0, "ripple");
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, "allones");
    run_op(16'h8421, 16'h7BDE, 16'h0003, 10, "stall10");

    // Asynchronous reset while segment 2 is being resolved.
    @(negedge clk);
    in_s = 16'hFFFF; in_c2 = 16'hFFFF; in_c4 = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrun_rst_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_sum", 32'(out_sum), 32'd0);
    chk("midrun_rst_carry", 32'(out_carry), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    run_op(16'h1234, 16'h0101, 16'h0010, 1, "after_rst");

    for (int i = 0; i < 8; i++)
      run_op(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), "rand");

`ifdef RESOLVER_EARLY_ACCEPT_EN
    // Back-to-back: one result every NS+1 cycles with in_valid held high.
    ta[0] = 16'h1234; tb[0] = 16'h0101; tc[0] = 16'h0010;
    ta[1] = 16'hFFFF; tb[1] = 16'h0001; tc[1] = 16'h0000;
    ta[2] = 16'hFFFF; tb[2] = 16'hFFFF; tc[2] = 16'hFFFF;
    @(negedge clk);
    in_s = ta[0]; in_c2 = tb[0]; in_c4 = tc[0]; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_s = ta[1]; in_c2 = tb[1]; in_c4 = tc[1];
    for (int i = 0; i < 3; i++) begin
      e = ref_sum(ta[i], tb[i], tc[i]);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!out_valid && lat < 50);
      chk("b2b_latency", 32'(lat), 32'(NS + 1));
      chk("b2b_sum", 32'(out_sum), 32'(e[BL-1:0]));
      chk("b2b_carry", 32'(out_carry), 32'(e[BL+1:BL]));
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      if (i == 2) in_valid = 1'b0;
      @(posedge clk); #1;
      if (i == 0) begin in_s = ta[2]; in_c2 = tb[2]; in_c4 = tc[2]; end
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_end_valid", 32'(out_valid), 32'd0);
    chk("b2b_end_in_ready", 32'(in_ready), 32'd1);
`else
    ta[0] = '0; tb[0] = '0; tc[0] = '0;
    ta[1] = '0; tb[1] = '0; tc[1] = '0;
    ta[2] = '0; tb[2] = '0; tc[2] = '0;
    e = '0; lat = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/redundant_resolver_seq.md
REDUNDANT_RESOLVER_SEQ -- requirements
Module: redundant_resolver_seq

Interface
REQ-001 SHALL have parameter BIT_LEN, default 1024, width of each redundant input term and of the binary result.
REQ-002 SHALL have parameter SEG_LEN, default 128, number of bits resolved per cycle; BIT_LEN SHALL be an integer multiple of SEG_LEN (elaboration error otherwise).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  redundant triple present.
REQ-006 SHALL have port in_ready  output  1  block accepts triple this cycle.
REQ-007 SHALL have port in_s  input  BIT_LEN  sum vector from compressor tree.
REQ-008 SHALL have port in_c2  input  BIT_LEN  first carry vector (already shifted, weight 1).
REQ-009 SHALL have port in_c4  input  BIT_LEN  second carry vector (already shifted, weight 1).
REQ-010 SHALL have port out_valid  output  1  resolved result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_sum  output  BIT_LEN  (in_s + in_c2 + in_c4) mod 2^BIT_LEN.
REQ-013 SHALL have port out_carry  output  2  bits BIT_LEN+1:BIT_LEN of the full sum (range 0..2).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready SHALL register in_s, in_c2, in_c4, clear segment index and 2-bit running carry, go RUN.
REQ-016 RUN: each cycle SHALL add segment k of the three registered terms plus running carry, write SEG_LEN result bits to out_sum segment k, update running carry with bits SEG_LEN+1:SEG_LEN of that segment sum, increment k.
REQ-017 RUN SHALL last exactly NUM_SEG=BIT_LEN/SEG_LEN cycles, LSB segment first; after last segment running carry SHALL load out_carry and FSM go DONE.
REQ-018 Latency: out_valid SHALL assert NUM_SEG+1 cycles after the accepting clock edge (NUM_SEG=1 gives 2).
REQ-019 DONE: out_valid=1; out_sum/out_carry SHALL stay stable while out_valid&!out_ready; on out_valid&out_ready go IDLE.
REQ-020 in_ready SHALL be 0 in RUN; in DONE per REQ-027.
REQ-021 Input buses need not be held after the accepting edge; changes on inputs outside an accepting edge SHALL have no effect.
REQ-022 out_sum SHALL be don't-care while out_valid=0 (verification SHALL not check it).

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, out_valid=0, out_sum=0, out_carry=0, segment index=0, running carry=0.
REQ-024 Reset during RUN or DONE SHALL discard the in-flight operation with no output handshake.
REQ-025 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge.

Configuration
REQ-026 Macro RESOLVER_EARLY_ACCEPT_EN SHALL select back-to-back operation.
REQ-027 Defined: in DONE, in_ready=out_ready; simultaneous out and in handshakes SHALL go directly to RUN with the new triple (throughput one result per NUM_SEG+1 cycles). Undefined: in_ready=0 in DONE; new triple accepted only in IDLE (one idle cycle between operations).

Verification
REQ-028 BIT_LEN=16, SEG_LEN=4: s=0x1234, c2=0x0101, c4=0x0010 -> out_sum=0x1345, out_carry=0, out_valid 5 cycles after accept.
REQ-029 s=0xFFFF, c2=0x0001, c4=0x0000 -> out_sum=0x0000, out_carry=1 (carry ripples through all 4 segments).
REQ-030 s=c2=c4=0xFFFF -> out_sum=0xFFFD, out_carry=2.
REQ-031 out_ready held 0 for 10 cycles in DONE -> out_valid, out_sum, out_carry unchanged, in_ready=0 (macro off); release -> one handshake, IDLE next cycle.
REQ-032 rst_n pulsed low during RUN segment 2 -> out_valid=0 immediately, next accepted triple resolves correctly.
REQ-033 Macro on, in_valid held high with 3 triples, out_ready=1 -> results every 5 cycles, no idle cycle, values match REQ-028..030.
